// File: rtl/vram_pkg.sv
// Shared tile-map geometry, fetch FSM states and the row-to-VRAM-base helper
// for vram_row_fetch and its line buffer.
package vram_pkg;
    localparam int TILE_COLS  = 40;
    localparam int TILE_ROWS  = 30;
    localparam int VRAM_DEPTH = 1200;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 8;
    localparam int COL_W      = 6;
    localparam int ROW_W      = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fetch_state_e;

    // row*40 as two shifts; the largest legal row (29) gives 1160.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
        logic [ADDR_W-1:0] w_r;
        w_r = {{(ADDR_W-ROW_W){1'b0}}, r};
        return (w_r << 5) + (w_r << 3);
    endfunction
endpackage

// File: rtl/vram_row_fetch_if.sv
// Request, VRAM read-port and display-read signals of vram_row_fetch.
// master = renderer/VRAM side, slave = the fetch unit.
interface vram_row_fetch_if;
    import vram_pkg::*;

    logic              start;
    logic [ROW_W-1:0]  row;
    logic              busy;
    logic              done;
    logic              re;
    logic [ADDR_W-1:0] VAddr;
    logic [DATA_W-1:0] VData;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] tile;

    modport master (output start, row, VData, col, input busy, done, re, VAddr, tile);
    modport slave  (input start, row, VData, col, output busy, done, re, VAddr, tile);
endinterface

// File: rtl/vram_line_buf.sv
// 40x8 tile-code line buffer: one synchronous write port, one registered read.
// VRAM_FETCH_DBUF_EN selects two banks (fetch fills the hidden one, i_swap flips).
module vram_line_buf
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [COL_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_swap,
    input  logic [COL_W-1:0]  i_col,
    output logic [DATA_W-1:0] o_tile
);
    logic w_col_ok;
    assign w_col_ok = (i_col < COL_W'(TILE_COLS));

`ifdef VRAM_FETCH_DBUF_EN
    logic [DATA_W-1:0] r_mem [2][TILE_COLS];
    logic              r_bank;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[~r_bank][i_waddr] <= i_wdata;
    end

    // The read on the swap edge still uses the old bank; the next col sees the new row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= 1'b0;
            o_tile <= '0;
        end else begin
            if (i_swap) r_bank <= ~r_bank;
            o_tile <= w_col_ok ? r_mem[r_bank][i_col] : '0;
        end
    end
`else
    logic [DATA_W-1:0] r_mem [TILE_COLS];
    logic              w_unused_swap;

    assign w_unused_swap = i_swap;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Single bank: reads during a fetch may mix old and new codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_tile <= '0;
        else        o_tile <= w_col_ok ? r_mem[i_col] : '0;
    end
`endif
endmodule

// File: rtl/vram_row_fetch.sv
// Fetches one 40-tile row from VRAM into the line buffer on request and serves
// tile codes by column. VRAM_FETCH_DBUF_EN enables the double-banked buffer.
module vram_row_fetch
    import vram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    vram_row_fetch_if.slave bus
);
    fetch_state_e      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_re;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_idx;

    logic [RD_LAT-1:0]            r_dl_vld;
    logic [RD_LAT-1:0][COL_W-1:0] r_dl_idx;

    logic w_pend;
    logic w_swap;
    logic [DATA_W-1:0] w_tile;

    // Reads still in flight ahead of the stage that is writing this cycle.
    always_comb begin
        w_pend = 1'b0;
        for (int k = 0; k < RD_LAT - 1; k++) w_pend = w_pend | r_dl_vld[k];
    end

    assign w_swap = (r_state == DRAIN) && !w_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_re    <= 1'b0;
            r_addr  <= '0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.row < ROW_W'(TILE_ROWS)) begin
                            r_state <= ISSUE;
                            r_busy  <= 1'b1;
                            r_re    <= 1'b1;
                            r_addr  <= row_base(bus.row);
                            r_idx   <= '0;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (r_idx == COL_W'(TILE_COLS - 1)) begin
                        r_re    <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx  <= r_idx + COL_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (!w_pend) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // re/index follow the VRAM latency so the last stage lines up with VData.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
            r_dl_idx <= '0;
        end else begin
            r_dl_vld[0] <= r_re;
            r_dl_idx[0] <= r_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_dl_vld[k] <= r_dl_vld[k-1];
                r_dl_idx[k] <= r_dl_idx[k-1];
            end
        end
    end

    vram_line_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_dl_vld[RD_LAT-1]),
        .i_waddr (r_dl_idx[RD_LAT-1]),
        .i_wdata (bus.VData),
        .i_swap  (w_swap),
        .i_col   (bus.col),
        .o_tile  (w_tile)
    );

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.re    = r_re;
    assign bus.VAddr = r_addr;
    assign bus.tile  = w_tile;
endmodule

// File: tb/tb_vram_row_fetch.sv
// Bench for vram_row_fetch: RD_LAT=1 and RD_LAT=2 instances driven in lock-step
// against a VRAM array model and an expected displayed-row array.
module tb_vram_row_fetch;
    import vram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vram_row_fetch_if if1 ();
    vram_row_fetch_if if2 ();

    vram_row_fetch #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    vram_row_fetch #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [7:0] vram [VRAM_DEPTH];
    logic [7:0] p1_d, p2_d1, p2_d2;

    always @(posedge clk) begin
        p1_d  <= (if1.re && if1.VAddr < 11'd1200) ? vram[if1.VAddr] : 8'h00;
        p2_d1 <= (if2.re && if2.VAddr < 11'd1200) ? vram[if2.VAddr] : 8'h00;
        p2_d2 <= p2_d1;
    end
    assign if1.VData = p1_d;
    assign if2.VData = p2_d2;

    logic        t_re   [2];
    logic        t_busy [2];
    logic        t_done [2];
    logic [10:0] t_addr [2];
    logic [7:0]  t_tile [2];
    assign t_re[0] = if1.re;     assign t_re[1] = if2.re;
    assign t_busy[0] = if1.busy; assign t_busy[1] = if2.busy;
    assign t_done[0] = if1.done; assign t_done[1] = if2.done;
    assign t_addr[0] = if1.VAddr; assign t_addr[1] = if2.VAddr;
    assign t_tile[0] = if1.tile; assign t_tile[1] = if2.tile;

    int n_chk = 0;
    int n_err = 0;
    int lat [2] = '{1, 2};

    // Expected contents of the displayed row
    logic [7:0] disp [TILE_COLS];
    bit         disp_valid = 1'b0;

    typedef struct {
        int row;
        bit pulses;
        int exp_base;
        int exp_nre;
        int exp_d1;
        int exp_d2;
        int c0;
        int c39;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input bit s, input int r);
        if1.start = s; if1.row = 5'(r);
        if2.start = s; if2.row = 5'(r);
    endtask

    task automatic drive_col(input int c);
        if1.col = 6'(c);
        if2.col = 6'(c);
    endtask

    task automatic chk_col(input string name, input int c, input int exp);
        @(negedge clk);
        drive_col(c);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_L%0d_col%0d", name, lat[i], c), int'(t_tile[i]), exp);
    endtask

    function automatic int model_tile(input int c);
        return (c < TILE_COLS) ? int'(disp[c]) : 0;
    endfunction

    task automatic run_fetch(input string name, input int r, input bit pulses, input bit sweep,
                             input int exp_base, input int exp_nre, input int exp_d1, input int exp_d2);
        int re_cnt [2];
        int first_re [2];
        int bad_addr [2];
        int done_cyc [2];
        int done_cnt [2];
        int busy_bad [2];
        int sweep_bad [2];
        int exp_d [2];
        int pcol;
        int e;
        bit inr;
        exp_d[0] = exp_d1;
        exp_d[1] = exp_d2;
        inr = (exp_nre != 0);
        for (int i = 0; i < 2; i++) begin
            re_cnt[i] = 0; first_re[i] = -1; bad_addr[i] = 0;
            done_cyc[i] = -1; done_cnt[i] = 0; busy_bad[i] = 0; sweep_bad[i] = 0;
        end
        pcol = -1;
        e = 0;
        @(negedge clk);
        drive_start(1'b1, r);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            drive_start(pulses && (cyc == 5 || cyc == 20), (r + 7) % TILE_ROWS);
            for (int i = 0; i < 2; i++) begin
                if (t_re[i]) begin
                    if (first_re[i] < 0) first_re[i] = cyc;
                    if (int'(t_addr[i]) != exp_base + re_cnt[i] || t_addr[i] >= 11'd1200)
                        bad_addr[i]++;
                    re_cnt[i]++;
                end
                if (t_done[i]) begin
                    done_cnt[i]++;
                    if (done_cyc[i] < 0) done_cyc[i] = cyc;
                end
                if (t_busy[i] != (inr && cyc < exp_d[i])) busy_bad[i]++;
`ifdef VRAM_FETCH_DBUF_EN
                if (sweep && pcol >= 0) begin
                    if (inr && cyc - 1 >= exp_d[i]) begin
                        e = int'(vram[exp_base + pcol]);
                        if (int'(t_tile[i]) != e) sweep_bad[i]++;
                    end else if (disp_valid) begin
                        e = int'(disp[pcol]);
                        if (int'(t_tile[i]) != e) sweep_bad[i]++;
                    end
                end
`endif
            end
            if (sweep) begin
                pcol = cyc % TILE_COLS;
                drive_col(pcol);
            end
        end
        drive_start(1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_L%0d_re_count", name, lat[i]), re_cnt[i], exp_nre);
            check($sformatf("%s_L%0d_first_re", name, lat[i]), first_re[i], inr ? 1 : -1);
            check($sformatf("%s_L%0d_addr_errs", name, lat[i]), bad_addr[i], 0);
            check($sformatf("%s_L%0d_done_cycle", name, lat[i]), done_cyc[i], exp_d[i]);
            check($sformatf("%s_L%0d_done_count", name, lat[i]), done_cnt[i], 1);
            check($sformatf("%s_L%0d_busy_errs", name, lat[i]), busy_bad[i], 0);
`ifdef VRAM_FETCH_DBUF_EN
            if (sweep) check($sformatf("%s_L%0d_sweep_errs", name, lat[i]), sweep_bad[i], 0);
`endif
        end
        if (inr) begin
            for (int c = 0; c < TILE_COLS; c++) disp[c] = vram[exp_base + c];
            disp_valid = 1'b1;
        end
    endtask

    task automatic reset_mid_fetch();
        int dn;
        int rn;
        dn = 0;
        rn = 0;
        @(negedge clk);
        drive_start(1'b1, 5);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            drive_start(1'b0, 0);
        end
        for (int i = 0; i < 2; i++) check($sformatf("midrst_L%0d_re_before", lat[i]), int'(t_re[i]), 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midrst_L%0d_re", lat[i]), int'(t_re[i]), 0);
            check($sformatf("midrst_L%0d_busy", lat[i]), int'(t_busy[i]), 0);
            check($sformatf("midrst_L%0d_addr", lat[i]), int'(t_addr[i]), 0);
            check($sformatf("midrst_L%0d_tile", lat[i]), int'(t_tile[i]), 0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (t_done[i]) dn++;
                if (t_re[i]) rn++;
            end
        end
        rst_n = 1'b1;
        disp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (t_done[i]) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_no_re", rn, 0);
    endtask

    vec_t tbl [6];

    initial begin
        int r;
        int nre;
        for (int a = 0; a < VRAM_DEPTH; a++) vram[a] = 8'(a);
        tbl[0] = '{3,  1'b0, 120,  40, 42, 43, 'h78, 'h9F};
        tbl[1] = '{29, 1'b0, 1160, 40, 42, 43, 'h88, 'hAF};
        tbl[2] = '{30, 1'b0, 0,    0,  1,  1,  'h88, 'hAF};
        tbl[3] = '{0,  1'b1, 0,    40, 42, 43, 'h00, 'h27};
        tbl[4] = '{31, 1'b0, 0,    0,  1,  1,  'h00, 'h27};
        tbl[5] = '{2,  1'b1, 80,   40, 42, 43, 'h50, 'h77};

        rst_n = 1'b0;
        drive_start(1'b0, 0);
        drive_col(0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_L%0d_re", lat[i]), int'(t_re[i]), 0);
            check($sformatf("rst_L%0d_busy", lat[i]), int'(t_busy[i]), 0);
            check($sformatf("rst_L%0d_done", lat[i]), int'(t_done[i]), 0);
            check($sformatf("rst_L%0d_addr", lat[i]), int'(t_addr[i]), 0);
            check($sformatf("rst_L%0d_tile", lat[i]), int'(t_tile[i]), 0);
        end
        drive_col(17);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check($sformatf("rst_L%0d_tile17", lat[i]), int'(t_tile[i]), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("idle_L%0d_re", lat[i]), int'(t_re[i]), 0);
            check($sformatf("idle_L%0d_busy", lat[i]), int'(t_busy[i]), 0);
            check($sformatf("idle_L%0d_done", lat[i]), int'(t_done[i]), 0);
        end
        chk_col("idle", 45, 0);

        for (int v = 0; v < 6; v++) begin
            run_fetch($sformatf("vec%0d_row%0d", v, tbl[v].row), tbl[v].row, tbl[v].pulses, 1'b0,
                      tbl[v].exp_base, tbl[v].exp_nre, tbl[v].exp_d1, tbl[v].exp_d2);
            chk_col($sformatf("vec%0d", v), 0, tbl[v].c0);
            chk_col($sformatf("vec%0d", v), 39, tbl[v].c39);
            chk_col($sformatf("vec%0d", v), 40, 0);
        end

        run_fetch("dbuf_row1", 1, 1'b0, 1'b0, 40, 40, 42, 43);
        run_fetch("dbuf_row2", 2, 1'b0, 1'b1, 80, 40, 42, 43);
        chk_col("dbuf", 5, 'h55);
        chk_col("dbuf", 45, 0);

        reset_mid_fetch();
        chk_col("postrst", 63, 0);
        run_fetch("fresh_row7", 7, 1'b0, 1'b0, 280, 40, 42, 43);
        chk_col("fresh", 0, 'h18);
        chk_col("fresh", 39, 'h3F);

        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < VRAM_DEPTH; a++) vram[a] = 8'($urandom);
            r = int'($urandom_range(0, 31));
            nre = (r < TILE_ROWS) ? TILE_COLS : 0;
            run_fetch($sformatf("rnd%0d_row%0d", it, r), r, (r < TILE_ROWS) && ($urandom_range(0, 1) == 1),
                      1'b1, r * TILE_COLS, nre, (nre != 0) ? 42 : 1, (nre != 0) ? 43 : 1);
            for (int k = 0; k < 4; k++) begin
                int c;
                c = int'($urandom_range(0, 63));
                if (c >= TILE_COLS || disp_valid) chk_col($sformatf("rnd%0d", it), c, model_tile(c));
            end
            chk_col($sformatf("rnd%0d", it), 39, model_tile(39));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vram_row_fetch.md
# vram_row_fetch

Reader-side counterpart to the VRAM writers: on request it fetches one 40-tile row (8-bit tile codes) from the 1200-entry VRAM (40×30 tiles) into a local line buffer. The display pipeline then reads tile codes by column at pixel rate. It sits between the VRAM read port and the VGA tile renderer and is kicked once per tile row during horizontal blanking.

## Interface
Parameters:
- RD_LAT, 1: VRAM read latency in cycles, from address presented to data valid; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to fetch a row; sampled only in IDLE.
- row  in  5  tile row index 0..29, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the row is fully buffered.
- re  out  1  VRAM read enable.
- VAddr  out  11  VRAM read address.
- VData  in  8  VRAM read data, valid RD_LAT cycles after the matching re.
- col  in  6  display-side column index.
- tile  out  8  tile code for col, registered.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 with row≤29 latches base=row*40, computed as (row<<5)+(row<<3) in 11 bits with max 1160, then goes to ISSUE. start=1 with row>29 goes straight to DONE; the buffer is left unchanged and no re is issued.
- ISSUE: re=1 and VAddr=base+i for i=0..39, one address per cycle. After i=39, go to DRAIN.
- Capture: a delay line of re and index, depth RD_LAT, writes VData into buffer[index] when the delayed re is high.
- DRAIN: wait until the last capture has happened, then go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- start in any state other than IDLE is ignored and is not queued.
- Display read: tile<=buffer[col] on every clock. col≥40 gives tile=8'h00.
- Reset at any time (async): state=IDLE, busy=0, done=0, re=0, VAddr=0, tile=8'h00, delay line cleared, buffer contents undefined, bank=0.

## Timing
- Cycle 0: start accepted.
- Cycles 1..40: re=1, VAddr=base..base+39.
- Last capture at cycle 40+RD_LAT.
- Cycle 41+RD_LAT: done=1 and busy=0.
- busy=1 on cycles 1..40+RD_LAT.
- Back-to-back: a new start is accepted in the cycle after done, i.e. the first IDLE cycle.
- Out-of-range row: done at cycle 1 and busy stays 0.
- Display read latency: 1 cycle (col at cycle n, tile at cycle n+1). It is independent of fetch activity.

## Configuration
- VRAM_FETCH_DBUF_EN defined: two 40×8 banks.
  - The fetch writes bank ~bank; the display reads bank.
  - bank toggles on the same edge that raises done, so tile reflects the new row from the first col sampled after done.
  - The out-of-range done does not toggle bank.
- Undefined: a single bank.
  - The fetch writes the displayed buffer directly, so reads during busy may return a mix of old and new codes.
  - The renderer must only start during blanking.

## Structure
- Package vram_pkg holds:
  - TILE_COLS=40, TILE_ROWS=30, VRAM_DEPTH=1200, ADDR_W=11, DATA_W=8.
  - The fetch state enum.
  - A function for row*TILE_COLS.
- Sub-module vram_line_buf: 40×8 storage (one or two banks per the macro) with one synchronous write port, one registered read port, the col≥40 zero rule, and bank select.

## Test plan
- Reset then idle: all outputs 0 and tile=8'h00 for any col.
- RD_LAT=1, VRAM[i]=i[7:0], start with row=3 -> VAddr 120..159 on cycles 1..40, done at cycle 42, then col=0 gives tile=8'h78 and col=39 gives 8'h9F.
- RD_LAT=2, row=29 -> last VAddr=1199, done at cycle 43, no address ≥1200 ever driven.
- row=30 -> done at cycle 1, re never asserted, buffer unchanged; start pulses during busy -> ignored, exactly one done.
- With VRAM_FETCH_DBUF_EN, fetch row 1 then row 2 while sweeping col -> tile shows row-1 data until done, row-2 data after; col=45 -> 8'h00.
- rst_n low at cycle 20 of a fetch -> re=0, busy=0, no done; a fresh start after release completes normally.
